// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the two-requester memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int WAIT_CNT_WIDTH = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/mem_bus_rr_pick.sv
// Combinational 2-way round-robin selector; on a tie the requester that was not granted last wins.
module mem_bus_rr_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  assign grant_valid = |req;

  always_comb begin
    grant_idx = REQ_FETCH;
    if (req[REQ_FETCH] && req[REQ_DATA]) begin
      grant_idx = ~last_grant;
    end else if (req[REQ_DATA]) begin
      grant_idx = REQ_DATA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (r0) and data (r1).
// Optional grant/conflict counters are built when MEM_BUS_ARBITER_PERF_CNT_EN is defined.
//
// state     | meaning
// ST_IDLE   | sample requests, latch the winner's command
// ST_ACCESS | memory strobe held for WAIT_STATES+1 cycles
// ST_DONE   | one-cycle ack to the owner
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  master_clk,
  input  logic                  rst_n,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
  output logic [15:0]           r0_grant_cnt,
  output logic [15:0]           r1_grant_cnt,
  output logic [15:0]           conflict_cnt,
`endif
  output logic                  busy,
  output logic                  owner
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(WAIT_STATES);

  state_e                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic                      last_grant_q, last_grant_d;

  logic                  r0_ack_d, r1_ack_d, mem_en_d, mem_we_d, busy_d, owner_d;
  logic [DATA_WIDTH-1:0] rdata_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  logic grant_valid, grant_idx;
  logic both_req;

  assign both_req = r0_req && r1_req;

  mem_bus_rr_pick u_pick (
    .req         ({r1_req, r0_req}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    last_grant_d = last_grant_q;
    r0_ack_d     = 1'b0;
    r1_ack_d     = 1'b0;
    rdata_d      = rdata;
    mem_en_d     = mem_en;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    owner_d      = owner;

    case (state_q)
      ST_IDLE: begin
        mem_en_d = 1'b0;
        if (grant_valid) begin
          mem_en_d     = 1'b1;
          mem_we_d     = (grant_idx == REQ_DATA) ? r1_we    : r0_we;
          mem_addr_d   = (grant_idx == REQ_DATA) ? r1_addr  : r0_addr;
          mem_wdata_d  = (grant_idx == REQ_DATA) ? r1_wdata : r0_wdata;
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          wait_cnt_d   = '0;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        wait_cnt_d = wait_cnt_q + WAIT_CNT_WIDTH'(1);
        if (wait_cnt_q == WAIT_LAST) begin
          // Write accesses leave the previous read data visible.
          if (!mem_we) begin
            rdata_d = mem_rdata;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          r0_ack_d = (owner == REQ_FETCH);
          r1_ack_d = (owner == REQ_DATA);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      last_grant_q <= REQ_DATA;
      r0_ack       <= 1'b0;
      r1_ack       <= 1'b0;
      rdata        <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      owner        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      last_grant_q <= last_grant_d;
      r0_ack       <= r0_ack_d;
      r1_ack       <= r1_ack_d;
      rdata        <= rdata_d;
      mem_en       <= mem_en_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      busy         <= busy_d;
      owner        <= owner_d;
    end
  end

`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_grant_cnt <= '0;
      r1_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else if (state_q == ST_IDLE) begin
      if (both_req) begin
        conflict_cnt <= sat_inc16(conflict_cnt);
      end
      if (grant_valid && (grant_idx == REQ_FETCH)) begin
        r0_grant_cnt <= sat_inc16(r0_grant_cnt);
      end
      if (grant_valid && (grant_idx == REQ_DATA)) begin
        r1_grant_cnt <= sat_inc16(r1_grant_cnt);
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf = both_req;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level model compared every cycle plus directed checks.
module tb_mem_bus_arbiter;

  localparam int WS = 2;

  logic        master_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [15:0] r0_addr = 0, r1_addr = 0;
  logic [7:0]  r0_wdata = 0, r1_wdata = 0;
  logic        r0_ack, r1_ack, mem_en, mem_we, busy, owner;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
  logic [15:0] r0_grant_cnt, r1_grant_cnt, conflict_cnt;
  logic        sat_req = 1'b0;
`endif

  logic        a_req = 0;
  logic [15:0] a_addr = 0;
  logic        a_ack, a_r1_ack, a_mem_en, a_mem_we, a_busy, a_owner;
  logic [7:0]  a_rdata, a_mem_wdata, a_mem_rdata;
  logic [15:0] a_mem_addr;
`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
  logic [15:0] a_g0, a_g1, a_conf;
`endif

  int n_chk = 0, n_pass = 0;
  bit cmp_en = 0;

  always #5 master_clk = ~master_clk;

  function automatic logic [7:0] rd_fn(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h3D;
  endfunction

  assign mem_rdata   = rd_fn(mem_addr);
  assign a_mem_rdata = rd_fn(a_mem_addr);

  mem_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(WS)) dut (
    .master_clk(master_clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
    .r0_grant_cnt(r0_grant_cnt), .r1_grant_cnt(r1_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
    .busy(busy), .owner(owner)
  );

  mem_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .master_clk(master_clk), .rst_n(rst_n),
    .r0_req(a_req), .r0_we(1'b0), .r0_addr(a_addr), .r0_wdata(8'h00), .r0_ack(a_ack),
    .r1_req(1'b0), .r1_we(1'b0), .r1_addr(16'h0000), .r1_wdata(8'h00), .r1_ack(a_r1_ack),
    .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
    .r0_grant_cnt(a_g0), .r1_grant_cnt(a_g1), .conflict_cnt(a_conf),
`endif
    .busy(a_busy), .owner(a_owner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction model: m_rem counts the cycles left in the current transaction
  // (WS+1 memory cycles followed by one ack cycle).
  int          m_rem;
  logic        m_owner, m_last, m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic        m_pick;
`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
  logic [15:0] m_g0, m_g1, m_conf;
`endif

  assign m_pick = (r0_req && r1_req) ? !m_last : r1_req;

  always @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_owner <= 0; m_last <= 1; m_we <= 0;
      m_addr <= 0; m_wdata <= 0; m_rdata <= 0;
`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
      m_g0 <= 0; m_g1 <= 0; m_conf <= 0;
`endif
    end else if (m_rem > 0) begin
      if (m_rem == 2 && !m_we) m_rdata <= rd_fn(m_addr);
      m_rem <= m_rem - 1;
    end else begin
`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
      if (sat_req) m_g0 <= 16'hFFFF;
      if (r0_req && r1_req && m_conf != 16'hFFFF) m_conf <= m_conf + 1;
      if ((r0_req || r1_req) && !m_pick && m_g0 != 16'hFFFF && !sat_req) m_g0 <= m_g0 + 1;
      if ((r0_req || r1_req) && m_pick && m_g1 != 16'hFFFF) m_g1 <= m_g1 + 1;
`endif
      if (r0_req || r1_req) begin
        m_owner <= m_pick;
        m_last  <= m_pick;
        m_we    <= m_pick ? r1_we : r0_we;
        m_addr  <= m_pick ? r1_addr : r0_addr;
        m_wdata <= m_pick ? r1_wdata : r0_wdata;
        m_rem   <= WS + 2;
      end
    end
  end

  always @(negedge master_clk) begin
    if (cmp_en) begin
      chk("cyc_r0_ack", r0_ack, (m_rem == 1) && !m_owner);
      chk("cyc_r1_ack", r1_ack, (m_rem == 1) && m_owner);
      chk("cyc_rdata", rdata, m_rdata);
      chk("cyc_mem_en", mem_en, m_rem >= 2);
      chk("cyc_mem_we", mem_we, m_we && (m_rem >= 2));
      chk("cyc_mem_addr", mem_addr, m_addr);
      chk("cyc_mem_wdata", mem_wdata, m_wdata);
      chk("cyc_busy", busy, m_rem > 0);
      chk("cyc_owner", owner, m_owner);
`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
      chk("cyc_r0_grant_cnt", r0_grant_cnt, m_g0);
      chk("cyc_r1_grant_cnt", r1_grant_cnt, m_g1);
      chk("cyc_conflict_cnt", conflict_cnt, m_conf);
`endif
    end
  end

  task automatic wait_ack(input bit idx, input logic [15:0] ea, input logic [7:0] ew,
                          output int n, output int en_c, output int addr_c,
                          output int we_c, output int oth, output bit ok);
    n = 0; en_c = 0; addr_c = 0; we_c = 0; oth = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge master_clk);
      n++;
      if (mem_en) en_c++;
      if (mem_en && mem_addr == ea) addr_c++;
      if (mem_en && mem_we && mem_wdata == ew) we_c++;
      if (idx ? r0_ack : r1_ack) oth++;
      if (idx ? r1_ack : r0_ack) ok = 1;
    end
  endtask

  initial begin
    int n, en_c, addr_c, we_c, oth, na, acks_in_rst;
    bit ok;
    int ack_cyc[4];
    logic ack_own[4];
    logic [7:0] ack_rd[4];

    repeat (3) @(negedge master_clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rdata", rdata, 0);

    // fetch read, 3 memory cycles, ack 4 cycles after the sampling edge
    r0_addr = 16'h0100; r0_we = 0; r0_req = 1;
    wait_ack(0, 16'h0100, 8'h00, n, en_c, addr_c, we_c, oth, ok);
    r0_req = 0;
    chk("rd_ack_seen", ok, 1);
    chk("rd_latency", n, 4);
    chk("rd_en_cycles", en_c, 3);
    chk("rd_addr_cycles", addr_c, 3);
    chk("rd_rdata", rdata, 8'h3C);
    chk("rd_r1_ack_quiet", oth, 0);
    @(negedge master_clk);
    chk("rd_ack_single", r0_ack, 0);

    // data write; rdata keeps the earlier read value
    r1_addr = 16'h2000; r1_we = 1; r1_wdata = 8'hA5; r1_req = 1;
    wait_ack(1, 16'h2000, 8'hA5, n, en_c, addr_c, we_c, oth, ok);
    r1_req = 0; r1_we = 0;
    chk("wr_ack_seen", ok, 1);
    chk("wr_latency", n, 4);
    chk("wr_we_cycles", we_c, 3);
    chk("wr_rdata_held", rdata, 8'h3C);
    chk("wr_r0_ack_quiet", oth, 0);
    @(negedge master_clk);
    chk("wr_ack_single", r1_ack, 0);
    chk("wr_mem_we_cleared", mem_we, 0);

    // both requesting continuously from reset: strict alternation, 5-cycle period
    rst_n = 0;
    @(negedge master_clk);
    r0_addr = 16'h0104; r1_addr = 16'h2008;
    r0_req = 1; r1_req = 1;
    rst_n = 1;
    na = 0;
    for (int i = 1; i <= 60 && na < 4; i++) begin
      @(negedge master_clk);
      if (r0_ack || r1_ack) begin
        ack_cyc[na] = i; ack_own[na] = owner; ack_rd[na] = rdata;
        chk("rr_ack_matches_owner", r1_ack, owner);
`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
        if (na == 2) begin
          chk("perf_r0_grants", r0_grant_cnt, 2);
          chk("perf_r1_grants", r1_grant_cnt, 1);
          chk("perf_conflicts_min", conflict_cnt >= 16'd2, 1);
        end
`endif
        na++;
        if (na == 4) begin r0_req = 0; r1_req = 0; end
      end
    end
    chk("rr_ack_count", na, 4);
    if (na == 4) begin
      chk("rr_first_latency", ack_cyc[0], 4);
      chk("rr_owner0", ack_own[0], 0);
      chk("rr_owner1", ack_own[1], 1);
      chk("rr_owner2", ack_own[2], 0);
      chk("rr_owner3", ack_own[3], 1);
      for (int j = 1; j < 4; j++) chk("rr_period", ack_cyc[j] - ack_cyc[j-1], 5);
      chk("rr_rdata0", ack_rd[0], 8'h38);
      chk("rr_rdata1", ack_rd[1], 8'h15);
    end
    @(negedge master_clk);

    // reset in the middle of a fetch access
    r0_addr = 16'h0100; r0_req = 1;
    @(negedge master_clk);
    @(negedge master_clk);
    chk("mid_in_access", mem_en, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_acks", {r0_ack, r1_ack}, 0);
    r0_req = 0;
    acks_in_rst = 0;
    repeat (3) begin
      @(negedge master_clk);
      if (r0_ack || r1_ack) acks_in_rst++;
    end
    chk("mid_no_ack", acks_in_rst, 0);
    rst_n = 1;
    r0_req = 1; r1_req = 1;
    wait_ack(0, 16'h0100, 8'h00, n, en_c, addr_c, we_c, oth, ok);
    r0_req = 0;
    chk("post_rst_tie_to_r0", ok, 1);
    chk("post_rst_r1_waits", oth, 0);
    wait_ack(1, 16'h2008, 8'h00, n, en_c, addr_c, we_c, oth, ok);
    r1_req = 0;
    chk("post_rst_r1_served", ok, 1);
    @(negedge master_clk);

`ifdef MEM_BUS_ARBITER_PERF_CNT_EN
    force dut.r0_grant_cnt = 16'hFFFF;
    sat_req = 1;
    @(negedge master_clk);
    release dut.r0_grant_cnt;
    sat_req = 0;
    r0_req = 1;
    wait_ack(0, 16'h0100, 8'h00, n, en_c, addr_c, we_c, oth, ok);
    r0_req = 0;
    chk("perf_saturated", r0_grant_cnt, 16'hFFFF);
    @(negedge master_clk);
`endif

    // zero wait states: single memory cycle, ack 2 cycles after grant
    a_addr = 16'h0305; a_req = 1;
    n = 0; en_c = 0; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge master_clk);
      n++;
      if (a_mem_en) en_c++;
      if (a_ack) ok = 1;
    end
    a_req = 0;
    chk("ws0_ack_seen", ok, 1);
    chk("ws0_latency", n, 2);
    chk("ws0_en_cycles", en_c, 1);
    chk("ws0_rdata", a_rdata, 8'h3B);
    @(negedge master_clk);
    chk("ws0_idle", a_busy, 0);

    repeat (2) @(negedge master_clk);
    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
